writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage; sits directly downstream of the memory stage and consumes its MEM_WB outputs plus the raw data-memory read response.
- Registers the MEM/WB boundary and formats load data (byte/half select, sign/zero extension).
- Buffers a dmem response that arrives while the pipeline is stalled.
- Drives the one-shot register-file write, the forwarding source and the in-order commit/retire counter.

Parameters:
- ORDER_W, 64, width of the retire-order counter

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pipe_stall  input  1  global hazard stall; 1 = WB register holds
- mem_valid  input  1  memory-stage slot holds an instruction
- mem_done  input  1  memory-stage result is fresh (dmem access complete or none needed)
- mem_pc  input  32  instruction PC
- mem_rd  input  5  destination register
- mem_regf_we  input  1  instruction writes rd
- mem_load  input  1  instruction is a load
- mem_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_addr_lo  input  2  alu_out[1:0], byte offset of the access
- mem_regfilemux_out  input  32  non-load result
- dmem_rdata  input  32  raw word read data
- dmem_resp  input  1  dmem response strobe, one cycle
- rf_we  output  1  register-file write enable
- rf_rd  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- fwd_valid  output  1  WB holds a valid rd-writing instruction
- fwd_rd  output  5  forwarding destination
- fwd_data  output  32  forwarding data
- commit_valid  output  1  retire pulse
- commit_pc  output  32  PC of retiring instruction
- commit_order  output  ORDER_W  retire index of that instruction

Behaviour:
- Reset (async, any cycle, including mid-stall with held data): all outputs 0; WB register invalid; fresh=0; hold_valid=0; hold_data=0; order counter=0.
- advance = !pipe_stall. On a rising edge with advance:
  - wb_valid <= mem_valid & mem_done.
  - The captured instruction's fields are registered.
  - fresh <= mem_valid & mem_done.
  - hold_valid <= 0.
- Response buffer: on a rising edge with dmem_resp=1 and pipe_stall=1: hold_data <= dmem_rdata, hold_valid <= 1.
- Load data source at capture: hold_valid ? hold_data : dmem_rdata.
- If dmem_resp=1 and advance=1 in the same cycle, live dmem_rdata is used and nothing is buffered.
- Load formatting, combinational before the register:
  - sh = src >> (8*mem_addr_lo).
  - LB: sign-extend sh[7:0]. LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]. LHU: zero-extend sh[15:0].
  - LW: sh.
  - Other funct3: 0.
  - Misaligned halves/words are not trapped; the shifted value is used as is (upper bits zero-filled before extension).
- Non-loads: the registered value is mem_regfilemux_out.
- Latency: result visible on rf_*/fwd_* and commit_* one cycle after the capture edge.
- rf_we = wb_valid & fresh & regf_we & (rd != 0).
  - One-shot: fresh clears on the next edge if advance=0, so a held instruction never re-writes or re-commits.
- fwd_valid = wb_valid & regf_we & (rd != 0).
  - Stays asserted while the register holds, so stalled consumers can still forward.
  - fwd_data is always the registered result.
  - With rd=0: fwd_valid=0 and fwd_data=0.
- commit_valid = wb_valid & fresh, regardless of regf_we (stores and branches retire too).
  - commit_order = counter value.
  - Counter increments on every edge where commit_valid=1.
  - Counter wraps modulo 2^ORDER_W.
- Bubbles (mem_valid=0 or mem_done=0 at capture): wb_valid=0; no write, no commit, no counter change.
- Back-to-back valid instructions with no stall: one commit per cycle, consecutive order values.

Test Plan:
- ALU instruction, rd=5, mem_regfilemux_out=0x1234_5678, no stall -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234_5678, commit_valid=1, commit_order=0.
- LB, addr_lo=2, dmem_rdata=0x0080_0000 -> rf_wdata=0xFFFF_FF80. Same stimulus as LBU -> rf_wdata=0x0000_0080.
- LHU, addr_lo=2, rdata=0xBEEF_0000 -> 0x0000_BEEF. LH, same stimulus -> 0xFFFF_BEEF. LW, addr_lo=0, rdata=0xDEAD_BEEF -> 0xDEAD_BEEF.
- Load; dmem_resp with rdata=0xAAAA_AAAA while pipe_stall=1; stall held 3 more cycles with dmem_rdata driven to 0 -> on release, captured LW result is 0xAAAA_AAAA. During the following 2-cycle stall: rf_we and commit_valid pulse exactly once, fwd_valid remains 1.
- Instruction with rd=0 and regf_we=1 -> rf_we=0, fwd_valid=0, commit_valid=1. Bubble with mem_done=0 -> no commit, order unchanged.
- Retire 3 instructions, then assert rst mid-stall with hold_valid=1 -> all outputs 0 immediately. After release, next retire has commit_order=0 and uses live dmem_rdata.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Writeback stage bus: MEM/WB inputs, raw dmem response, and the
// register-file / forwarding / commit outputs.
interface writeback_stage_if #(
    parameter int unsigned ORDER_W = 64
);
    // Memory-stage side
    logic                pipe_stall;
    logic                mem_valid;
    logic                mem_done;
    logic [31:0]         mem_pc;
    logic [4:0]          mem_rd;
    logic                mem_regf_we;
    logic                mem_load;
    logic [2:0]          mem_funct3;
    logic [1:0]          mem_addr_lo;
    logic [31:0]         mem_regfilemux_out;
    logic [31:0]         dmem_rdata;
    logic                dmem_resp;

    // Register file, forwarding and commit side
    logic                rf_we;
    logic [4:0]          rf_rd;
    logic [31:0]         rf_wdata;
    logic                fwd_valid;
    logic [4:0]          fwd_rd;
    logic [31:0]         fwd_data;
    logic                commit_valid;
    logic [31:0]         commit_pc;
    logic [ORDER_W-1:0]  commit_order;

    // Upstream driver (pipeline / bench) view
    modport master (
        output pipe_stall, mem_valid, mem_done, mem_pc, mem_rd, mem_regf_we,
               mem_load, mem_funct3, mem_addr_lo, mem_regfilemux_out,
               dmem_rdata, dmem_resp,
        input  rf_we, rf_rd, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               commit_valid, commit_pc, commit_order
    );

    // Writeback stage view
    modport slave (
        input  pipe_stall, mem_valid, mem_done, mem_pc, mem_rd, mem_regf_we,
               mem_load, mem_funct3, mem_addr_lo, mem_regfilemux_out,
               dmem_rdata, dmem_resp,
        output rf_we, rf_rd, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               commit_valid, commit_pc, commit_order
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: registers the MEM/WB boundary, formats load data,
// buffers a dmem response that lands during a stall, and drives the one-shot
// register-file write, the forwarding source and the retire counter.
module writeback_stage #(
    parameter int unsigned ORDER_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    logic                advance;

    // WB pipeline register
    logic                wb_valid;
    logic                fresh;
    logic [31:0]         wb_pc;
    logic [4:0]          wb_rd;
    logic                wb_regf_we;
    logic [31:0]         wb_result;

    // Response buffer for dmem data that arrives while stalled
    logic                hold_valid;
    logic [31:0]         hold_data;

    logic [ORDER_W-1:0]  order_cnt;

    // Load formatting
    logic [31:0]         load_src;
    logic [31:0]         load_sh;
    logic [31:0]         load_fmt;
    logic [31:0]         result_next;
    logic                capture_valid;
    logic                rd_nonzero;
    logic                commit;

    assign advance       = !bus.pipe_stall;
    assign capture_valid = bus.mem_valid & bus.mem_done;

    // Select load source, align by byte offset, extend per load type
    always_comb begin
        load_src = hold_valid ? hold_data : bus.dmem_rdata;
        load_sh  = load_src >> {bus.mem_addr_lo, 3'b000};
        case (bus.mem_funct3)
            3'b000:  load_fmt = {{24{load_sh[7]}}, load_sh[7:0]};
            3'b001:  load_fmt = {{16{load_sh[15]}}, load_sh[15:0]};
            3'b010:  load_fmt = load_sh;
            3'b100:  load_fmt = {24'd0, load_sh[7:0]};
            3'b101:  load_fmt = {16'd0, load_sh[15:0]};
            default: load_fmt = 32'd0;
        endcase
        result_next = bus.mem_load ? load_fmt : bus.mem_regfilemux_out;
    end

    // MEM/WB register; fresh drops on any held edge so writes/commits are one-shot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            fresh      <= 1'b0;
            wb_pc      <= 32'd0;
            wb_rd      <= 5'd0;
            wb_regf_we <= 1'b0;
            wb_result  <= 32'd0;
        end else if (advance) begin
            wb_valid   <= capture_valid;
            fresh      <= capture_valid;
            wb_pc      <= bus.mem_pc;
            wb_rd      <= bus.mem_rd;
            wb_regf_we <= bus.mem_regf_we;
            wb_result  <= result_next;
        end else begin
            fresh      <= 1'b0;
        end
    end

    // Capture a dmem response during a stall; released once the stage advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= 32'd0;
        end else if (advance) begin
            hold_valid <= 1'b0;
        end else if (bus.dmem_resp) begin
            hold_valid <= 1'b1;
            hold_data  <= bus.dmem_rdata;
        end
    end

    assign commit     = wb_valid & fresh;
    assign rd_nonzero = (wb_rd != 5'd0);

    // Retire counter advances once per committed instruction, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            order_cnt <= '0;
        end else if (commit) begin
            order_cnt <= order_cnt + ORDER_W'(1);
        end
    end

    assign bus.rf_we        = commit & wb_regf_we & rd_nonzero;
    assign bus.rf_rd        = wb_rd;
    assign bus.rf_wdata     = wb_result;

    // Forwarding stays live while the register holds; x0 never forwards
    assign bus.fwd_valid    = wb_valid & wb_regf_we & rd_nonzero;
    assign bus.fwd_rd       = wb_rd;
    assign bus.fwd_data     = rd_nonzero ? wb_result : 32'd0;

    assign bus.commit_valid = commit;
    assign bus.commit_pc    = wb_pc;
    assign bus.commit_order = order_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: load formatting, stall buffering,
// one-shot write/commit, x0 handling, bubbles and mid-stall reset.
module tb_writeback_stage;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   we_pulses;
    int   commit_pulses;

    writeback_stage_if #(.ORDER_W(64)) bus ();

    writeback_stage #(.ORDER_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one memory-stage slot
    task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                             input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] mux, input logic [31:0] rdata,
                             input logic resp);
        bus.mem_valid          = 1'b1;
        bus.mem_done           = 1'b1;
        bus.mem_pc             = pc;
        bus.mem_rd             = rd;
        bus.mem_regf_we        = we;
        bus.mem_load           = ld;
        bus.mem_funct3         = f3;
        bus.mem_addr_lo        = lo;
        bus.mem_regfilemux_out = mux;
        bus.dmem_rdata         = rdata;
        bus.dmem_resp          = resp;
    endtask

    // Advance one clock and settle past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rf_we"},     64'(bus.rf_we),        64'd0);
        check_val({tag, "_rf_wdata"},  64'(bus.rf_wdata),     64'd0);
        check_val({tag, "_fwd_valid"}, 64'(bus.fwd_valid),    64'd0);
        check_val({tag, "_fwd_data"},  64'(bus.fwd_data),     64'd0);
        check_val({tag, "_commit"},    64'(bus.commit_valid), 64'd0);
        check_val({tag, "_order"},     bus.commit_order,      64'd0);
        check_val({tag, "_pc"},        64'(bus.commit_pc),    64'd0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                             input logic [31:0] rdata, input logic [31:0] exp,
                             input logic [63:0] order);
        set_instr(32'h104, 5'd6, 1'b1, 1'b1, f3, lo, 32'hFFFF_FFFF, rdata, 1'b1);
        step();
        check_val({tag, "_wdata"}, 64'(bus.rf_wdata), 64'(exp));
        check_val({tag, "_order"}, bus.commit_order, order);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        bus.pipe_stall = 1'b0;
        set_instr(32'h0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0);
        bus.mem_valid = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // ALU result
        set_instr(32'h100, 5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 1'b0);
        step();
        check_val("alu_rf_we",    64'(bus.rf_we),        64'd1);
        check_val("alu_rf_rd",    64'(bus.rf_rd),        64'd5);
        check_val("alu_wdata",    64'(bus.rf_wdata),     64'h1234_5678);
        check_val("alu_commit",   64'(bus.commit_valid), 64'd1);
        check_val("alu_order",    bus.commit_order,      64'd0);
        check_val("alu_pc",       64'(bus.commit_pc),    64'h100);
        check_val("alu_fwd",      64'(bus.fwd_valid),    64'd1);
        check_val("alu_fwd_rd",   64'(bus.fwd_rd),       64'd5);
        check_val("alu_fwd_data", 64'(bus.fwd_data),     64'h1234_5678);

        // Load formatting, back-to-back retires
        load_case("lb",     3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80, 64'd1);
        load_case("lbu",    3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080, 64'd2);
        load_case("lhu",    3'b101, 2'd2, 32'hBEEF_0000, 32'h0000_BEEF, 64'd3);
        load_case("lh",     3'b001, 2'd2, 32'hBEEF_0000, 32'hFFFF_BEEF, 64'd4);
        load_case("lw",     3'b010, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 64'd5);
        load_case("lw_mis", 3'b010, 2'd1, 32'hDEAD_BEEF, 32'h00DE_ADBE, 64'd6);
        load_case("lb_b3",  3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F, 64'd7);
        load_case("bad_f3", 3'b011, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 64'd8);

        // x0 destination still retires but never writes or forwards
        set_instr(32'h180, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'hCAFE_F00D, 32'h0, 1'b0);
        step();
        check_val("x0_rf_we",    64'(bus.rf_we),        64'd0);
        check_val("x0_fwd",      64'(bus.fwd_valid),    64'd0);
        check_val("x0_fwd_data", 64'(bus.fwd_data),     64'd0);
        check_val("x0_commit",   64'(bus.commit_valid), 64'd1);
        check_val("x0_order",    bus.commit_order,      64'd9);

        // Bubble: memory result not done
        set_instr(32'h184, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1111_1111, 32'h0, 1'b0);
        bus.mem_done = 1'b0;
        step();
        check_val("bub_commit", 64'(bus.commit_valid), 64'd0);
        check_val("bub_rf_we",  64'(bus.rf_we),        64'd0);
        check_val("bub_fwd",    64'(bus.fwd_valid),    64'd0);
        step();
        check_val("bub_order",  bus.commit_order,      64'd10);

        // Response arrives during a stall and must be buffered
        bus.pipe_stall = 1'b1;
        set_instr(32'h200, 5'd7, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'hAAAA_AAAA, 1'b1);
        step();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) step();
        check_val("stall_no_commit", 64'(bus.commit_valid), 64'd0);
        bus.pipe_stall = 1'b0;
        step();
        check_val("buf_wdata", 64'(bus.rf_wdata),     64'hAAAA_AAAA);
        check_val("buf_pc",    64'(bus.commit_pc),    64'h200);
        check_val("buf_order", bus.commit_order,      64'd10);
        we_pulses     = int'(bus.rf_we);
        commit_pulses = int'(bus.commit_valid);
        bus.pipe_stall = 1'b1;
        set_instr(32'h204, 5'd9, 1'b1, 1'b0, 3'd0, 2'd0, 32'h9999_9999, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            we_pulses     += int'(bus.rf_we);
            commit_pulses += int'(bus.commit_valid);
            check_val("hold_fwd",      64'(bus.fwd_valid), 64'd1);
            check_val("hold_fwd_data", 64'(bus.fwd_data),  64'hAAAA_AAAA);
        end
        check_val("hold_we_pulses",     64'(we_pulses),     64'd1);
        check_val("hold_commit_pulses", 64'(commit_pulses), 64'd1);
        check_val("hold_order",         bus.commit_order,   64'd11);

        // Retire three, then reset mid-stall with a buffered response
        bus.pipe_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_instr(32'h300 + 32'(4 * i), 5'd3, 1'b1, 1'b0, 3'd0, 2'd0,
                      32'h0000_0030 + 32'(i), 32'h0, 1'b0);
            step();
            check_val("r3_order", bus.commit_order, 64'd11 + 64'(i));
        end
        bus.pipe_stall = 1'b1;
        set_instr(32'h400, 5'd8, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h5555_5555, 1'b1);
        step();
        check_val("pre_rst_fwd", 64'(bus.fwd_valid), 64'd1);
        rst = 1'b1;
        #2;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        bus.pipe_stall = 1'b0;
        set_instr(32'h400, 5'd8, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0, 32'h1357_2468, 1'b1);
        step();
        check_val("post_rst_wdata",  64'(bus.rf_wdata),     64'h1357_2468);
        check_val("post_rst_order",  bus.commit_order,      64'd0);
        check_val("post_rst_commit", 64'(bus.commit_valid), 64'd1);
        bus.mem_valid = 1'b0;
        step();
        check_val("post_rst_next", bus.commit_order, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
